// File: rtl/truth_table_sweeper.sv
// Sweeps x3..x0 through all 16 vectors and captures y into a truth table.
// Optional golden-table comparison enabled by defining SWEEP_CHECK_EN.
module truth_table_sweeper #(
  parameter int DWELL = 20
`ifdef SWEEP_CHECK_EN
  , parameter logic [15:0] EXPECTED = 16'h0000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        y,
  output logic        x0,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
`ifdef SWEEP_CHECK_EN
  output logic        mismatch,
`endif
  output logic        valid
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  state_t        state;
  logic [3:0]    vec;
  logic [CW-1:0] dwell;
  logic [15:0]   cap;
  logic [15:0]   full;

  assign {x3, x2, x1, x0} = vec;

  // Table as it stands once this cycle's y lands in its slot.
  always_comb begin
    full = cap;
    full[vec] = y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= 4'd0;
      dwell     <= '0;
      cap       <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      table_out <= 16'h0000;
`ifdef SWEEP_CHECK_EN
      mismatch  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          // DONE falls back to IDLE's start check so a held start
          // relaunches right after the one-cycle done pulse.
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            state <= DRIVE;
            vec   <= 4'd0;
            dwell <= '0;
            busy  <= 1'b1;
            valid <= 1'b0;
`ifdef SWEEP_CHECK_EN
            mismatch <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          if (dwell == LAST) begin
            dwell    <= '0;
            cap[vec] <= y;
            if (vec == 4'd15) begin
              vec       <= 4'd0;
              table_out <= full;
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              valid     <= 1'b1;
`ifdef SWEEP_CHECK_EN
              mismatch  <= (full != EXPECTED);
`endif
            end else begin
              vec <= vec + 4'd1;
            end
          end else begin
            dwell <= dwell + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          vec   <= 4'd0;
          dwell <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Random-stimulus bench for truth_table_sweeper at DWELL=20 and DWELL=1,
// compared every cycle against a sweep-timeline model.
module tb_truth_table_sweeper;

  localparam int D0 = 20;
  localparam int D1 = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start;
  logic [3:0]  xa, xb;
  logic        ya, yb;
  logic [1:0]  busy, done, valid, mm;
  logic [15:0] tab0, tab1;
  logic [15:0] lut0, lut1;
  logic [1:0]  noise;
  bit          chk_on = 0;
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  // Downstream blocks: table lookup, with junk outside the capture cycle.
  assign ya = lut0[xa] ^ noise[0];
  assign yb = lut1[xb] ^ noise[1];

`ifdef SWEEP_CHECK_EN
  truth_table_sweeper #(.DWELL(D0), .EXPECTED(16'hAAAA)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .y(ya),
    .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]),
    .busy(busy[0]), .done(done[0]), .table_out(tab0),
    .mismatch(mm[0]), .valid(valid[0]));
  truth_table_sweeper #(.DWELL(D1), .EXPECTED(16'hAAAA)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .y(yb),
    .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]),
    .busy(busy[1]), .done(done[1]), .table_out(tab1),
    .mismatch(mm[1]), .valid(valid[1]));
`else
  assign mm = 2'b00;
  truth_table_sweeper #(.DWELL(D0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .y(ya),
    .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]),
    .busy(busy[0]), .done(done[0]), .table_out(tab0),
    .valid(valid[0]));
  truth_table_sweeper #(.DWELL(D1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .y(yb),
    .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]),
    .busy(busy[1]), .done(done[1]), .table_out(tab1),
    .valid(valid[1]));
`endif

  function automatic int dwk(int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic logic [15:0] lutk(int k);
    return (k == 0) ? lut0 : lut1;
  endfunction

  // Truth table of a named 4-input function, bit i = f(i).
  function automatic logic [15:0] tt(int f);
    logic [15:0] r;
    logic [3:0] v;
    r = 16'h0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      case (f)
        0: r[i] = v[3] & v[2];
        1: r[i] = v[0];
        2: r[i] = v[1];
        default: r[i] = ~v[0];
      endcase
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // Model: a sweep is just "cycles since accepted start"; the table
  // published at the end is the function's own truth table.
  bit          m_act[2];
  int          m_t[2];
  bit          m_done[2];
  bit          m_valid[2];
  bit          m_mm[2];
  logic [15:0] m_tab[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_t[k] = 0; m_done[k] = 0;
      m_valid[k] = 0; m_mm[k] = 0; m_tab[k] = 16'h0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_act[k] = 0; m_t[k] = 0; m_done[k] = 0;
        m_valid[k] = 0; m_mm[k] = 0; m_tab[k] = 16'h0;
      end else if (m_act[k]) begin
        m_t[k]++;
        if (m_t[k] == 16 * dwk(k)) begin
          m_act[k] = 0;
          m_done[k] = 1;
          m_valid[k] = 1;
          m_tab[k] = lutk(k);
          m_mm[k] = (lutk(k) != 16'hAAAA);
        end
      end else begin
        m_done[k] = 0;
        if (start[k]) begin
          m_act[k] = 1; m_t[k] = 0;
          m_valid[k] = 0; m_mm[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_act[k] && (m_t[k] % dwk(k)) != dwk(k) - 1)
        noise[k] = 1'($urandom);
      else
        noise[k] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("x%0d", k), {28'h0, (k == 0) ? xa : xb},
            {28'h0, m_act[k] ? 4'(m_t[k] / dwk(k)) : 4'd0});
        chk($sformatf("busy%0d", k), {31'h0, busy[k]}, {31'h0, m_act[k]});
        chk($sformatf("done%0d", k), {31'h0, done[k]}, {31'h0, m_done[k]});
        chk($sformatf("valid%0d", k), {31'h0, valid[k]},
            {31'h0, m_valid[k]});
        chk($sformatf("table%0d", k), {16'h0, (k == 0) ? tab0 : tab1},
            {16'h0, m_tab[k]});
`ifdef SWEEP_CHECK_EN
        chk($sformatf("mismatch%0d", k), {31'h0, mm[k]}, {31'h0, m_mm[k]});
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 2'b00;
    lut0 = 16'h0;
    lut1 = 16'h0;
    noise = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1;
    chk("rst_table", {16'h0, tab0}, 32'h0);
    chk("rst_busy", {31'h0, busy[0]}, 32'h0);
    chk("rst_valid", {31'h0, valid[0]}, 32'h0);

    // y = x3&x2 at DWELL=20, y = x0 at DWELL=1
    lut0 = tt(0);
    lut1 = tt(1);
    start = 2'b11;
    @(posedge clk);
    @(negedge clk);
    start = 2'b00;
    repeat (16) @(posedge clk);
    #1;
    chk("d1_table", {16'h0, tab1}, 32'h0000AAAA);
    chk("d1_done", {31'h0, done[1]}, 32'h1);
    repeat (303) @(posedge clk);
    #1;
    chk("d20_busy_319", {31'h0, busy[0]}, 32'h1);
    @(posedge clk);
    #1;
    chk("d20_table", {16'h0, tab0}, 32'h0000F000);
    chk("d20_done", {31'h0, done[0]}, 32'h1);
    chk("d20_valid", {31'h0, valid[0]}, 32'h1);
    @(posedge clk);
    #1;
    chk("d20_done_drop", {31'h0, done[0]}, 32'h0);

    // reset at edge 100 of a sweep
    @(negedge clk);
    start = 2'b01;
    @(posedge clk);
    @(negedge clk);
    start = 2'b00;
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_table", {16'h0, tab0}, 32'h0);
    chk("abort_x", {28'h0, xa}, 32'h0);
    chk("abort_busy", {31'h0, busy[0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 2'b01;
    @(posedge clk);
    @(negedge clk);
    start = 2'b00;
    repeat (320) @(posedge clk);
    #1;
    chk("resweep_table", {16'h0, tab0}, 32'h0000F000);

    // start held high, y = x1
    @(negedge clk);
    lut0 = tt(2);
    lut1 = tt(2);
    start = 2'b11;
    @(posedge clk);
    repeat (320) @(posedge clk);
    #1;
    chk("held_table", {16'h0, tab0}, 32'h0000CCCC);
    chk("held_done", {31'h0, done[0]}, 32'h1);
    @(posedge clk);
    #1;
    chk("held_restart", {31'h0, busy[0]}, 32'h1);
    repeat (400) @(posedge clk);
    @(negedge clk);
    start = 2'b00;
    repeat (340) @(posedge clk);

    // y = ~x0
    @(negedge clk);
    lut0 = tt(3);
    start = 2'b01;
    @(posedge clk);
    @(negedge clk);
    start = 2'b00;
    repeat (320) @(posedge clk);
    #1;
    chk("inv_table", {16'h0, tab0}, 32'h00005555);
`ifdef SWEEP_CHECK_EN
    chk("inv_mismatch", {31'h0, mm[0]}, 32'h1);
    @(negedge clk);
    start = 2'b01;
    @(posedge clk);
    #1;
    chk("mismatch_clear", {31'h0, mm[0]}, 32'h0);
    @(negedge clk);
    start = 2'b00;
    repeat (330) @(posedge clk);
`endif

    // randomized sweeps, luts and occasional resets
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (!m_act[0] && $urandom_range(0, 3) == 0) lut0 = 16'($urandom);
      if (!m_act[1] && $urandom_range(0, 3) == 0) lut1 = 16'($urandom);
      if ($urandom_range(0, 4) == 0) lut1 = (!m_act[1]) ? 16'hAAAA : lut1;
      start[0] = ($urandom_range(0, 7) == 0);
      start[1] = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 1999) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
